// File: rtl/left_shift_deser_if.sv
// left_shift_deser_if: serial strobe inputs and registered word/handshake outputs of the deserializer
interface left_shift_deser_if #(parameter int DW = 4);
  logic          en;
  logic          sync;
  logic          sin;
  logic          ready;
  logic [DW-1:0] q;
  logic          valid;
  logic          busy;
  logic          overrun;
  logic          parity_err;
  modport master (output en, sync, sin, ready, input q, valid, busy, overrun, parity_err);
  modport slave  (input en, sync, sin, ready, output q, valid, busy, overrun, parity_err);
endinterface

// File: rtl/left_shift_deser.sv
// left_shift_deser: MSB-first serial-to-parallel receiver with valid/ready output and sticky overrun
// Define LEFT_SHIFT_DESER_PARITY_EN to append an even-parity bit to each frame and report parity_err
module left_shift_deser #(parameter int DW = 4) (
  input logic clk,
  input logic async_rst,
  left_shift_deser_if.slave s
);
`ifdef LEFT_SHIFT_DESER_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif
  localparam int CW = $clog2(FL);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, nxt;
  logic [DW-1:0] sh, q, word;
  logic [CW-1:0] cnt;
  logic valid, overrun, pe, pe_nxt, last, done, take;
  assign last = cnt == CW'(FL - 1);
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) state <= IDLE;
    else state <= nxt;
  always_comb nxt = (s.en && s.sync) ? RECV : (s.en && state == RECV && last) ? IDLE : state;
  always_comb begin
    done = s.en && !s.sync && state == RECV && last;
    take = !valid || s.ready;
`ifdef LEFT_SHIFT_DESER_PARITY_EN
    word = sh;
    pe_nxt = ^sh ^ s.sin;
`else
    word = {sh[DW-2:0], s.sin};
    pe_nxt = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) begin
      sh <= '0;
      cnt <= '0;
      q <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
      pe <= 1'b0;
    end else begin
      if (s.en && (s.sync || state == RECV)) sh <= {sh[DW-2:0], s.sin};
      if (s.en && s.sync) cnt <= CW'(1);
      else if (s.en && state == RECV) cnt <= last ? '0 : cnt + CW'(1);
      // a completion that cannot be stored leaves q/valid alone and only flags the loss
      if (done && take) begin
        q <= word;
        valid <= 1'b1;
        pe <= pe_nxt;
      end else if (done) overrun <= 1'b1;
      else if (valid && s.ready) valid <= 1'b0;
    end
  always_comb begin
    s.busy = state == RECV;
    s.q = q;
    s.valid = valid;
    s.overrun = overrun;
    s.parity_err = pe;
  end
endmodule
